// File: rtl/fifo_pkg.sv
// fifo_pkg: defaults and level-compare helpers shared by the FIFO variants.
// Revision: 1.0
`default_nettype none

package fifo_pkg;

  localparam int FIFO_DEFAULT_WIDTH = 8;
  localparam int FIFO_DEFAULT_DEPTH = 16;

  function automatic logic level_ge(input int lvl, input int thr);
    return lvl >= thr;
  endfunction

  function automatic logic level_le(input int lvl, input int thr);
    return lvl <= thr;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x DATA_WIDTH storage, one synchronous write port, one asynchronous read port.
// Revision: 1.0
`default_nettype none

module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  wr_en_i,
  input  logic [AW-1:0]         wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]         rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

`default_nettype wire

// File: rtl/sync_fifo.sv
// sync_fifo: circular-buffer FWFT FIFO with level, thresholds and flush.
// Optional sticky overflow/underflow flags enabled by macro SYNC_FIFO_ERR_EN. Revision: 1.0
`default_nettype none

module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = FIFO_DEFAULT_WIDTH,
  parameter int DEPTH        = FIFO_DEFAULT_DEPTH,
  parameter int AFULL_LEVEL  = DEPTH - 2,
  parameter int AEMPTY_LEVEL = 2,
  parameter int AW           = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [AW:0]           level,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clear
);

  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic                  push, pop;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  // Acceptance looks only at registered occupancy, never at the opposite port.
  assign full         = (count_q == CNT_FULL);
  assign empty        = (count_q == '0);
  assign almost_full  = level_ge(32'(count_q), AFULL_LEVEL);
  assign almost_empty = level_le(32'(count_q), AEMPTY_LEVEL);
  assign wr_ready     = !full;
  assign rd_valid     = !empty;
  assign level        = count_q;
  assign push         = wr_valid && !full && !flush;
  assign pop          = rd_ready && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clock     (clock),
    .wr_en_i   (push),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_data),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (mem_rd_data)
  );

  assign rd_data = empty ? '0 : mem_rd_data;

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // A new error event wins over a simultaneous clear.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (err_clear) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wr_valid && full && !flush)  overflow_d  = 1'b1;
    if (rd_ready && empty && !flush) underflow_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  logic unused_err_clear;
  assign unused_err_clear = err_clear;
  assign overflow         = 1'b0;
  assign underflow        = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed scenarios plus randomized traffic against a queue-based reference model.
// Revision: 1.0
`default_nettype none

module tb_sync_fifo;

  localparam int DW     = 8;
  localparam int DEPTH  = 16;
  localparam int AW     = $clog2(DEPTH);
  localparam int AFULL  = DEPTH - 2;
  localparam int AEMPTY = 2;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          flush, wr_valid, rd_ready, err_clear;
  logic [DW-1:0] wr_data;
  logic          wr_ready, rd_valid, full, empty, almost_full, almost_empty;
  logic          overflow, underflow;
  logic [DW-1:0] rd_data;
  logic [AW:0]   level;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] model_q[$];
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;

  always #5 clock = ~clock;

  sync_fifo #(
    .DATA_WIDTH   (DW),
    .DEPTH        (DEPTH),
    .AFULL_LEVEL  (AFULL),
    .AEMPTY_LEVEL (AEMPTY)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .flush        (flush),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .rd_ready     (rd_ready),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .level        (level),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow),
    .err_clear    (err_clear)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic check_outputs(input string tag);
    int n;
    logic [DW-1:0] head;
    n    = model_q.size();
    head = (n > 0) ? model_q[0] : '0;
    check_eq({tag, ".level"},  32'(level),        32'(n));
    check_eq({tag, ".full"},   32'(full),         32'(n == DEPTH));
    check_eq({tag, ".empty"},  32'(empty),        32'(n == 0));
    check_eq({tag, ".afull"},  32'(almost_full),  32'(n >= AFULL));
    check_eq({tag, ".aempty"}, 32'(almost_empty), 32'(n <= AEMPTY));
    check_eq({tag, ".wrdy"},   32'(wr_ready),     32'(n != DEPTH));
    check_eq({tag, ".rvld"},   32'(rd_valid),     32'(n != 0));
    check_eq({tag, ".rdata"},  32'(rd_data),      32'(head));
    check_eq({tag, ".ovf"},    32'(overflow),     32'(m_ovf));
    check_eq({tag, ".unf"},    32'(underflow),    32'(m_unf));
  endtask

  // Reference behaviour for one rising edge, evaluated on pre-edge state.
  task automatic model_edge(input logic wv, input logic [DW-1:0] wd, input logic rr,
                            input logic fl, input logic ec);
    int  n;
    logic push_ok, pop_ok;
    n = model_q.size();
`ifdef SYNC_FIFO_ERR_EN
    if (ec) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (!fl && wv && n == DEPTH) m_ovf = 1'b1;
    if (!fl && rr && n == 0)     m_unf = 1'b1;
`endif
    if (fl) begin
      model_q.delete();
    end else begin
      push_ok = wv && (n < DEPTH);
      pop_ok  = rr && (n > 0);
      if (pop_ok)  void'(model_q.pop_front());
      if (push_ok) model_q.push_back(wd);
    end
  endtask

  task automatic cyc(input string tag, input logic wv, input logic [DW-1:0] wd,
                     input logic rr, input logic fl, input logic ec);
    wr_valid  = wv;
    wr_data   = wd;
    rd_ready  = rr;
    flush     = fl;
    err_clear = ec;
    @(posedge clock);
    model_edge(wv, wd, rr, fl, ec);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    wr_valid  = 1'b0;
    rd_ready  = 1'b0;
    err_clear = 1'b0;
    wr_data   = '0;
    repeat (2) @(posedge clock);
    #1;
    check_outputs("reset");
    reset_n = 1'b1;

    // Fill to full, then one rejected push.
    for (int i = 1; i <= DEPTH; i++) cyc("fill", 1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
    cyc("ovf_push", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);

    // Drain in order, then one pop on empty.
    for (int i = 0; i < DEPTH; i++) cyc("drain", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cyc("unf_pop", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Steady level 5 with simultaneous push/pop, pointers wrap.
    for (int i = 0; i < 5; i++) cyc("lvl5", 1'b1, DW'(8'h30 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc("pp5", 1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc("drain5", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Empty push+pop: pop ignored. Full push+pop: push rejected.
    cyc("pp_empty", 1'b1, 8'h5C, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < DEPTH; i++) cyc("refill", 1'b1, DW'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    cyc("pp_full", 1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);

    // Down to level 9, flush with a push pending, then clear errors.
    for (int i = 0; i < 6; i++) cyc("to9", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cyc("flush", 1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    cyc("errclr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset between edges.
    for (int i = 0; i < 4; i++) cyc("prerst", 1'b1, DW'(8'h90 + i), 1'b0, 1'b0, 1'b0);
    cyc("prerst_unf", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    model_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    check_outputs("rst_async");
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Randomized traffic with shifting push/pop bias.
    for (int blk = 0; blk < 20; blk++) begin
      int wb, rb;
      wb = $urandom_range(10, 90);
      rb = $urandom_range(10, 90);
      for (int i = 0; i < 100; i++) begin
        cyc("rand",
            $urandom_range(0, 99) < wb,
            DW'($urandom),
            $urandom_range(0, 99) < rb,
            $urandom_range(0, 99) < 1,
            $urandom_range(0, 99) < 3);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sync_fifo.md
# sync_fifo

Parametrised single-clock FIFO for byte/word streams between producers (UART/command decoders) and the LCD controller, replacing the fixed 16×8 shift-register FIFO. Circular buffer with read/write pointers instead of data shifting; supports configurable width and depth, simultaneous push and pop, an occupancy count, almost-full/almost-empty thresholds and synchronous flush. Read side is first-word-fall-through: the head entry is always presented on `rd_data`.

## Interface
- `DATA_WIDTH`, default 8: entry width in bits.
- `DEPTH`, default 16: number of entries; power of two, ≥ 2. `AW = $clog2(DEPTH)`.
- `AFULL_LEVEL`, default `DEPTH-2`: `almost_full` asserts when count ≥ this value.
- `AEMPTY_LEVEL`, default 2: `almost_empty` asserts when count ≤ this value.
- `clock`  in  1  the block's single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous clear of contents.
- `wr_valid`  in  1  push request.
- `wr_data`  in  DATA_WIDTH  data to push.
- `wr_ready`  out  1  `!full`; push accepted when `wr_valid && wr_ready`.
- `rd_ready`  in  1  pop request (consume head).
- `rd_valid`  out  1  `!empty`; pop accepted when `rd_ready && rd_valid`.
- `rd_data`  out  DATA_WIDTH  head entry; 0 when empty.
- `level`  out  AW+1  current occupancy, 0..DEPTH.
- `full`, `empty`, `almost_full`, `almost_empty`  out  1 each  status flags.
- `overflow`, `underflow`  out  1 each  sticky error flags (see Configuration).
- `err_clear`  in  1  clears sticky error flags.

## Operation
- State: `wr_ptr`, `rd_ptr` (AW bits, wrap naturally modulo DEPTH), `count` (AW+1 bits); storage array not reset.
- Push: `mem[wr_ptr] <= wr_data`, `wr_ptr++`. Pop: `rd_ptr++`.
- count: +1 on push only, −1 on pop only, unchanged on both or neither.
- Acceptance uses registered state only: when full, a push is rejected even if a pop occurs the same cycle; when empty, a pop is ignored even if a push occurs the same cycle.
- Simultaneous accepted push and pop (0 < count < DEPTH): both pointers advance, count unchanged.
- `flush`: pointers and count to 0; overrides push/pop in that cycle; does not clear error flags.
- Flags purely from count: `full = count==DEPTH`, `empty = count==0`, `almost_full = count>=AFULL_LEVEL`, `almost_empty = count<=AEMPTY_LEVEL`.
- `rd_data = empty ? 0 : mem[rd_ptr]` (combinational read).

## Timing
- Reset values: count 0, `empty` 1, `rd_valid` 0, `full` 0, `wr_ready` 1, `almost_empty` 1, `almost_full` 0, `level` 0, `rd_data` 0, `overflow` 0, `underflow` 0.
- Reset assertion mid-operation discards contents immediately (asynchronous); deassertion sampled on next rising edge.
- Write-to-read latency: data pushed at edge N appears on `rd_data` with `rd_valid`=1 after edge N (one cycle).
- Pop at edge N: next entry on `rd_data` after edge N; all flags and `level` update on the same edge as the push/pop causing them.
- Sustained throughput: one push and one pop per cycle.

## Configuration
- `SYNC_FIFO_ERR_EN` defined: `overflow` sets on `wr_valid && full`, `underflow` sets on `rd_ready && empty` (flush cycle excluded); both sticky until `err_clear` or reset; set takes priority over `err_clear` in the same cycle.
- Undefined: `overflow`/`underflow` tied 0, `err_clear` ignored; port list unchanged so instantiations need no edits.

## Structure
- Shared package `fifo_pkg`: default width/depth constants and the level-compare helper used by all FIFO variants.
- Sub-module `fifo_mem`: DEPTH×DATA_WIDTH array, one synchronous write port, one asynchronous read port; pointer/count/flag logic stays in `sync_fifo`.

## Test plan
- Reset, then 16 pushes 0x01..0x10 (DEPTH=16) → `full`=1 at 16, `almost_full`=1 from level 14; 17th push 0xFF rejected, `overflow`=1 with macro.
- From full, 16 pops → data 0x01..0x10 in order, `empty`=1, `rd_data`=0; extra pop sets `underflow`.
- Level 5, push 0xAA and pop same cycle for 20 cycles → `level` stays 5, pointers wrap, output order preserved.
- Empty, push+pop same cycle → pop ignored, `level`=1, `rd_data`=pushed value next cycle; full, push+pop → push rejected, `level`=DEPTH−1.
- Level 9, assert `flush` with `wr_valid` → `level`=0, `empty`=1, error flags unchanged; `err_clear` → flags 0.
- Assert `reset_n`=0 mid-stream between edges → all outputs at reset values immediately.
